// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state numbering, opcodes and
// datapath mux/ALU select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // States that wait on the memory handshake and are guarded by the timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access; flags the cycle
// on which another stall would exceed the allowed limit.
module mem_wait_timer #(
  parameter int LIMIT = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT > 0 ? LIMIT - 1 : 0);
  localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tick && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (LIMIT > 0) && tick && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the R-type/LW/SW/ADDI datapath with memory
// handshake stalls, illegal-opcode flagging and a sticky timeout fault.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic       retired,
  output logic       fault,
  output logic [3:0] state_dbg
);

  state_t           state, state_nxt;
  logic             is_sw;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_nxt != state) || !is_mem_state(state)),
    .tick    (is_mem_state(state) && !mem_ready),
    .count   (wait_cnt),
    .expired (timed_out)
  );

  // Load/store class is captured in DECODE so MEMADR need not re-read the IR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      is_sw <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) is_sw <= (opcode == OP_SW);
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nxt  = state;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUOp      = ALUOP_ADD;
    illegal_op = 1'b0;
    retired    = 1'b0;
    fault      = 1'b0;
    state_dbg  = state;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          PCWrite   = 1'b1;
          IRWrite   = 1'b1;
          state_nxt = S_DECODE;
        end else if (timed_out) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_ADDI:      state_nxt = S_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)      state_nxt = S_MEMWB;
        else if (timed_out) state_nxt = S_FAULT;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        retired   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retired   = 1'b1;
          state_nxt = S_FETCH;
        end else if (timed_out) begin
          state_nxt = S_FAULT;
        end
      end
      S_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        retired   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        retired   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FAULT:  fault = 1'b1;
      default:  state_nxt = S_FAULT;
    endcase

    // Reset aborts the current instruction: nothing may write or retire.
    if (rst) begin
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      ALUOp      = ALUOP_ADD;
      illegal_op = 1'b0;
      retired    = 1'b0;
      fault      = 1'b0;
      state_dbg  = '0;
    end
  end

  // A stalled access is always diverted to FAULT before the counter reaches the limit.
  a_wait_bound: assert property (@(posedge clk) disable iff (rst)
    (MEM_TIMEOUT == 0) || (wait_cnt < CNT_W'(MEM_TIMEOUT)));

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed vector table, hand-written stall and
// fault sequences, and randomized traffic against a micro-step queue model.
module tb_multicycle_ctrl_fsm;

  localparam int TO = 4;
  localparam logic [5:0] JUNK = 6'h3f;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IorD, IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp;
  logic       MemRead, MemWrite, MemtoReg, illegal_op, retired, fault;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .illegal_op(illegal_op),
    .retired(retired), .fault(fault), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       pcw, iord, irw, regdst, regwr, srca;
    logic [1:0] srcb;
    logic       memrd, memwr, m2r;
    logic [1:0] aluop;
    logic       ill, ret, flt;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    string      name;
    logic       r;
    logic [5:0] op;
    logic       rdy;
    ctl_t       exp;
  } vec_t;

  ctl_t act;
  always_comb act = {PCWrite, IorD, IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                     MemRead, MemWrite, MemtoReg, ALUOp, illegal_op, retired, fault, state_dbg};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input ctl_t got, input ctl_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%05h want=%05h", name, got, exp);
    end
  endtask

  // Control word for a step, written straight from the per-state output list.
  function automatic ctl_t ew(input int s, input logic rdy = 1'b0, input logic ill = 1'b0);
    ctl_t w = '0;
    w.st = 4'(s);
    case (s)
      0:  begin w.memrd = 1; w.srcb = 2'b01; w.pcw = rdy; w.irw = rdy; end
      2:  begin w.srca = 1; w.srcb = 2'b10; end
      3:  begin w.memrd = 1; w.iord = 1; end
      4:  begin w.regwr = 1; w.m2r = 1; w.ret = 1; end
      5:  begin w.memwr = 1; w.iord = 1; w.ret = rdy; end
      6:  begin w.srca = 1; w.aluop = 2'b10; end
      7:  begin w.regwr = 1; w.regdst = 1; w.ret = 1; end
      8:  begin w.srca = 1; w.srcb = 2'b10; end
      9:  begin w.regwr = 1; w.ret = 1; end
      15: w.flt = 1;
      default: ;
    endcase
    w.ill = ill;
    return w;
  endfunction

  // Reference model: current step plus a queue of remaining steps of the instruction.
  int cur = 0;
  int waits = 0;
  int plan[$];

  function automatic ctl_t model_exp(input logic r, input logic [5:0] op, input logic rdy);
    logic legal;
    if (r) return '0;
    legal = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd8);
    return ew(cur, rdy, (cur == 1) && !legal);
  endfunction

  task automatic model_step(input logic r, input logic [5:0] op, input logic rdy);
    int prev = cur;
    if (r) begin
      cur = 0;
      plan.delete();
    end else if (cur == 15) begin
      cur = 15;
    end else if (cur == 1) begin
      plan.delete();
      case (op)
        6'd0:  begin plan.push_back(6); plan.push_back(7); end
        6'd35: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
        6'd43: begin plan.push_back(2); plan.push_back(5); end
        6'd8:  begin plan.push_back(8); plan.push_back(9); end
        default: ;
      endcase
      cur = (plan.size() > 0) ? plan.pop_front() : 0;
    end else if ((cur == 0 || cur == 3 || cur == 5) && !rdy) begin
      waits++;
      if (TO > 0 && waits >= TO) cur = 15;
    end else if (cur == 0) begin
      cur = 1;
    end else begin
      cur = (plan.size() > 0) ? plan.pop_front() : 0;
    end
    if (r || cur != prev) waits = 0;
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic rdy);
    @(negedge clk);
    rst = r;
    opcode = op;
    mem_ready = rdy;
    #1;
  endtask

  task automatic finish_cycle(input logic r, input logic [5:0] op, input logic rdy);
    @(posedge clk);
    model_step(r, op, rdy);
  endtask

  task automatic run_vec(input string name, input logic r, input logic [5:0] op,
                         input logic rdy, input ctl_t exp);
    drive(r, op, rdy);
    check(name, act, exp);
    finish_cycle(r, op, rdy);
  endtask

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic [5:0] op,
                     input logic rdy, input ctl_t exp);
    vec_t v;
    v.name = n; v.r = r; v.op = op; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset and the basic instruction flows.
    add("rst0", 1, JUNK, 1, '0);
    add("rst1", 1, JUNK, 0, '0);
    add("lw_fetch", 0, JUNK, 1, ew(0, 1));
    add("lw_dec", 0, 6'd35, 1, ew(1));
    add("lw_adr_oplatched", 0, 6'd43, 1, ew(2));
    add("lw_rd", 0, JUNK, 1, ew(3));
    add("lw_wb", 0, JUNK, 1, ew(4));
    add("r_fetch", 0, JUNK, 1, ew(0, 1));
    add("r_dec", 0, 6'd0, 1, ew(1));
    add("r_exec", 0, JUNK, 1, ew(6));
    add("r_wb", 0, JUNK, 1, ew(7));
    // SW with three stalled cycles in MEMWR.
    add("sw_fetch_wait", 0, JUNK, 0, ew(0));
    add("sw_fetch", 0, JUNK, 1, ew(0, 1));
    add("sw_dec", 0, 6'd43, 1, ew(1));
    add("sw_adr_oplatched", 0, 6'd35, 1, ew(2));
    add("sw_wr_stall0", 0, JUNK, 0, ew(5));
    add("sw_wr_stall1", 0, JUNK, 0, ew(5));
    add("sw_wr_stall2", 0, JUNK, 0, ew(5));
    add("sw_wr_done", 0, JUNK, 1, ew(5, 1));
    // Illegal opcode, then ready arriving exactly on the timeout cycle.
    add("ill_fetch", 0, JUNK, 1, ew(0, 1));
    add("ill_dec", 0, 6'b000100, 1, ew(1, 0, 1));
    add("lim_stall0", 0, JUNK, 0, ew(0));
    add("lim_stall1", 0, JUNK, 0, ew(0));
    add("lim_stall2", 0, JUNK, 0, ew(0));
    add("lim_ready", 0, JUNK, 1, ew(0, 1));
    add("addi_dec", 0, 6'd8, 0, ew(1));
    add("addi_ex", 0, JUNK, 0, ew(8));
    add("addi_wb", 0, JUNK, 0, ew(9));
    // Fetch timeout into sticky FAULT, cleared only by reset.
    add("to_stall0", 0, JUNK, 0, ew(0));
    add("to_stall1", 0, JUNK, 0, ew(0));
    add("to_stall2", 0, JUNK, 0, ew(0));
    add("to_stall3", 0, JUNK, 0, ew(0));
    add("fault_a", 0, JUNK, 1, ew(15));
    add("fault_b", 0, 6'd35, 0, ew(15));
    add("fault_rst", 1, JUNK, 1, '0);
    add("fault_cleared", 0, JUNK, 0, ew(0));
    // Reset during MEMWB and during a completing MEMWR.
    add("wb_fetch", 0, JUNK, 1, ew(0, 1));
    add("wb_dec", 0, 6'd35, 1, ew(1));
    add("wb_adr", 0, JUNK, 1, ew(2));
    add("wb_rd", 0, JUNK, 1, ew(3));
    add("wb_rst", 1, JUNK, 1, '0);
    add("wb_after_rst", 0, JUNK, 1, ew(0, 1));
    add("wr_dec", 0, 6'd43, 1, ew(1));
    add("wr_adr", 0, JUNK, 1, ew(2));
    add("wr_rst", 1, JUNK, 1, '0);
    add("wr_after_rst", 0, JUNK, 0, ew(0));

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i].name, vecs[i].r, vecs[i].op, vecs[i].rdy, vecs[i].exp);

    // Stall counts do not carry from FETCH into MEMRD.
    run_vec("carry_rst", 1, JUNK, 0, '0);
    for (int i = 0; i < 3; i++) run_vec("carry_fetch_stall", 0, JUNK, 0, ew(0));
    run_vec("carry_fetch", 0, JUNK, 1, ew(0, 1));
    run_vec("carry_dec", 0, 6'd35, 1, ew(1));
    run_vec("carry_adr", 0, JUNK, 0, ew(2));
    for (int i = 0; i < 3; i++) run_vec("carry_rd_stall", 0, JUNK, 0, ew(3));
    run_vec("carry_rd_done", 0, JUNK, 1, ew(3));
    run_vec("carry_wb", 0, JUNK, 0, ew(4));

    // MEMRD timeout, then FAULT holds under arbitrary inputs.
    run_vec("rdto_fetch", 0, JUNK, 1, ew(0, 1));
    run_vec("rdto_dec", 0, 6'd35, 1, ew(1));
    run_vec("rdto_adr", 0, JUNK, 1, ew(2));
    for (int i = 0; i < TO; i++) run_vec("rdto_stall", 0, JUNK, 0, ew(3));
    for (int i = 0; i < 12; i++)
      run_vec("rdto_sticky", 0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), ew(15));
    run_vec("rdto_rst", 1, JUNK, 0, '0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic       r, rdy;
      logic [5:0] op;
      int         pick;
      r = ($urandom_range(0, 99) < 2) || ((cur == 15) && ($urandom_range(0, 7) == 0));
      pick = $urandom_range(0, 4);
      case (pick)
        0: op = 6'd0;
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd8;
        default: op = 6'($urandom_range(0, 63));
      endcase
      rdy = ($urandom_range(0, 99) < 70);
      drive(r, op, rdy);
      check($sformatf("rand_%0d", i), act, model_exp(r, op, rdy));
      finish_cycle(r, op, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
